// File: rtl/rsc_encoder_pipe_if.sv
// Handshake bundle between the RSC encoder and its bit source / beat sink.
// master: the stimulus and consumer side. slave: the encoder.
interface rsc_encoder_pipe_if;
    logic In_Valid;
    logic In_Ready;
    logic In_Bit;
    logic Out_Valid;
    logic Out_Ready;
    logic Out_Sys;
    logic Out_Par;
    logic Out_Tail;

    modport master (
        output In_Valid, In_Bit, Out_Ready,
        input  In_Ready, Out_Valid, Out_Sys, Out_Par, Out_Tail
    );

    modport slave (
        input  In_Valid, In_Bit, Out_Ready,
        output In_Ready, Out_Valid, Out_Sys, Out_Par, Out_Tail
    );
endinterface

// File: rtl/rsc_encoder_pipe.sv
// 8-state RSC encoder (feedback 1+D^2+D^3, parity 1+D+D^3) with a registered output beat.
// Define RSC_ENC_TERM_EN to append three trellis-termination beats per block.
module rsc_encoder_pipe #(
    parameter int unsigned K_MAX = 6144,
    parameter int unsigned CW    = 13
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              Start,
    input  logic [CW-1:0]     BlockLen,
    output logic              Start_Err,
    output logic              Busy,
    output logic              Done,
    rsc_encoder_pipe_if.slave bus
);

    localparam logic [CW-1:0] LEN_MAX = CW'(K_MAX);
    localparam logic [CW-1:0] ONE     = CW'(1);

`ifdef RSC_ENC_TERM_EN
    typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;
    logic [1:0] tail_cnt;
`else
    typedef enum logic [1:0] {IDLE, DATA, DRAIN} state_t;
`endif

    state_t        state;
    logic [2:0]    s;          // {s1, s2, s3}
    logic [CW-1:0] len;
    logic [CW-1:0] cnt;

    logic out_free, out_fire, in_fire, len_ok, last_bit;
    logic d_a, d_par, t_sys, t_par;

    assign out_free = !bus.Out_Valid || bus.Out_Ready;
    assign out_fire = bus.Out_Valid && bus.Out_Ready;
    assign in_fire  = (state == DATA) && bus.In_Valid && out_free;
    assign len_ok   = (BlockLen != '0) && (BlockLen <= LEN_MAX);
    assign last_bit = (cnt == len - ONE);

    assign bus.In_Ready = (state == DATA) && out_free;
    assign Busy         = (state != IDLE);

    // Data beat feeds u into the recursion; a tail beat picks u so the feedback a is 0.
    assign d_a   = bus.In_Bit ^ s[1] ^ s[0];
    assign d_par = d_a ^ s[2] ^ s[0];
    assign t_sys = s[1] ^ s[0];
    assign t_par = s[2] ^ s[0];

`ifndef RSC_ENC_TERM_EN
    assign bus.Out_Tail = 1'b0;
`endif

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state         <= IDLE;
            s             <= '0;
            len           <= '0;
            cnt           <= '0;
            Start_Err     <= 1'b0;
            Done          <= 1'b0;
            bus.Out_Valid <= 1'b0;
            bus.Out_Sys   <= 1'b0;
            bus.Out_Par   <= 1'b0;
`ifdef RSC_ENC_TERM_EN
            bus.Out_Tail  <= 1'b0;
            tail_cnt      <= '0;
`endif
        end else begin
            Start_Err <= 1'b0;
            Done      <= 1'b0;
            if (out_fire)
                bus.Out_Valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (Start) begin
                        if (len_ok) begin
                            len   <= BlockLen;
                            cnt   <= '0;
                            s     <= '0;
                            state <= DATA;
                        end else begin
                            Start_Err <= 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (in_fire) begin
                        bus.Out_Valid <= 1'b1;
                        bus.Out_Sys   <= bus.In_Bit;
                        bus.Out_Par   <= d_par;
                        s             <= {d_a, s[2], s[1]};
                        cnt           <= cnt + ONE;
`ifdef RSC_ENC_TERM_EN
                        bus.Out_Tail  <= 1'b0;
                        if (last_bit) begin
                            tail_cnt <= '0;
                            state    <= TAIL;
                        end
`else
                        if (last_bit)
                            state <= DRAIN;
`endif
                    end
                end

`ifdef RSC_ENC_TERM_EN
                TAIL: begin
                    if (out_free) begin
                        bus.Out_Valid <= 1'b1;
                        bus.Out_Sys   <= t_sys;
                        bus.Out_Par   <= t_par;
                        bus.Out_Tail  <= 1'b1;
                        s             <= {1'b0, s[2], s[1]};
                        tail_cnt      <= tail_cnt + 2'd1;
                        if (tail_cnt == 2'd2)
                            state <= DRAIN;
                    end
                end
`endif

                DRAIN: begin
                    if (out_fire) begin
                        Done  <= 1'b1;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsc_encoder_pipe.sv
// Randomized self-checking bench for rsc_encoder_pipe against a sequence-level RSC model.
// Honours RSC_ENC_TERM_EN the same way as the design.
module tb_rsc_encoder_pipe;

    localparam int K_MAX = 6144;
    localparam int CW    = 13;
`ifdef RSC_ENC_TERM_EN
    localparam int TAILS = 3;
`else
    localparam int TAILS = 0;
`endif

    logic          Clock = 1'b0;
    logic          nReset = 1'b0;
    logic          Start = 1'b0;
    logic [CW-1:0] BlockLen = '0;
    logic          Start_Err, Busy, Done;

    rsc_encoder_pipe_if bus();

    rsc_encoder_pipe #(.K_MAX(K_MAX), .CW(CW)) dut (
        .Clock     (Clock),
        .nReset    (nReset),
        .Start     (Start),
        .BlockLen  (BlockLen),
        .Start_Err (Start_Err),
        .Busy      (Busy),
        .Done      (Done),
        .bus       (bus.slave)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;

    logic blk_bits [0:K_MAX-1];
    logic exp_sys  [0:K_MAX+2];
    logic exp_par  [0:K_MAX+2];
    logic exp_tail [0:K_MAX+2];
    logic obs_sys  [0:K_MAX+2];
    logic obs_par  [0:K_MAX+2];
    logic obs_tail [0:K_MAX+2];
    logic a_seq    [0:K_MAX+2];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Feedback sequence value a_i, zero before the block starts
    function automatic logic av(input int i);
        return (i < 0) ? 1'b0 : a_seq[i];
    endfunction

    // a_i = u_i ^ a_{i-2} ^ a_{i-3};  z_i = a_i ^ a_{i-1} ^ a_{i-3}
    task automatic build_expected(input int k);
        for (int i = 0; i < k; i++) begin
            a_seq[i]    = blk_bits[i] ^ av(i-2) ^ av(i-3);
            exp_sys[i]  = blk_bits[i];
            exp_par[i]  = a_seq[i] ^ av(i-1) ^ av(i-3);
            exp_tail[i] = 1'b0;
        end
        for (int i = k; i < k + TAILS; i++) begin
            a_seq[i]    = 1'b0;
            exp_sys[i]  = av(i-2) ^ av(i-3);
            exp_par[i]  = av(i-1) ^ av(i-3);
            exp_tail[i] = 1'b1;
        end
    endtask

    // mode 0: full rate, 1: Out_Ready toggles, 2: random, 3: stray Start during DATA
    task automatic run_block(input int k, input int mode);
        int in_idx = 0;
        int out_idx = 0;
        int cyc = -1;
        int limit = 6 * k + 100;
        bit stall = 0;
        bit tog = 1;
        bit injected = 0;
        bit done_seen = 0;
        logic ps = 0, pp = 0, pt = 0;
        build_expected(k);
        bus.Out_Ready = 1'b1;
        bus.In_Valid  = 1'b0;
        Start    = 1'b1;
        BlockLen = CW'(k);
        while (!done_seen && cyc < limit) begin
            @(posedge Clock); #1;
            cyc++;
            Start = 1'b0;
            if (cyc == 0) check("busy_after_start", Busy, 1);
            if (stall) begin
                check("hold_valid", bus.Out_Valid, 1);
                check("hold_sys", bus.Out_Sys, ps);
                check("hold_par", bus.Out_Par, pp);
                check("hold_tail", bus.Out_Tail, pt);
            end
            if (Done) begin
                done_seen = 1;
                check("beat_count", out_idx, k + TAILS);
                check("busy_at_done", Busy, 0);
                if (mode == 0) check("done_cycle", cyc, k + 1 + TAILS);
            end else begin
                case (mode)
                    1: begin bus.Out_Ready = tog; tog = !tog; end
                    2: bus.Out_Ready = ($urandom_range(0, 3) != 0);
                    default: bus.Out_Ready = 1'b1;
                endcase
                bus.In_Valid = (in_idx < k) && (mode != 2 || $urandom_range(0, 3) != 0);
                bus.In_Bit   = (in_idx < k) ? blk_bits[in_idx] : 1'b0;
                if (mode == 3 && in_idx == 2 && !injected) begin
                    Start    = 1'b1;
                    BlockLen = CW'(3);
                    injected = 1;
                end
                #1;
                if (bus.Out_Valid && !bus.Out_Ready)
                    check("in_ready_stall", bus.In_Ready, 0);
                if (bus.Out_Valid && bus.Out_Ready) begin
                    if (out_idx < k + TAILS) begin
                        check("beat_sys", bus.Out_Sys, exp_sys[out_idx]);
                        check("beat_par", bus.Out_Par, exp_par[out_idx]);
                        check("beat_tail", bus.Out_Tail, exp_tail[out_idx]);
                        obs_sys[out_idx]  = bus.Out_Sys;
                        obs_par[out_idx]  = bus.Out_Par;
                        obs_tail[out_idx] = bus.Out_Tail;
                    end else begin
                        check("extra_beat", out_idx, k + TAILS - 1);
                    end
                    out_idx++;
                end
                if (bus.In_Valid && bus.In_Ready) in_idx++;
                stall = bus.Out_Valid && !bus.Out_Ready;
                ps = bus.Out_Sys; pp = bus.Out_Par; pt = bus.Out_Tail;
            end
        end
        if (!done_seen) check("done_timeout", 0, 1);
        bus.In_Valid  = 1'b0;
        Start         = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock); #1;
            check("idle_done", Done, 0);
            check("idle_busy", Busy, 0);
        end
    endtask

    task automatic check_impulse();
        int isys [7] = '{1, 0, 0, 0, 1, 0, 1};
        int itail[7] = '{0, 0, 0, 0, 1, 1, 1};
        for (int i = 0; i < 4 + TAILS; i++) begin
            check("imp_sys", obs_sys[i], isys[i]);
            check("imp_par", obs_par[i], 1);
            check("imp_tail", obs_tail[i], itail[i]);
        end
    endtask

    task automatic load_impulse();
        for (int i = 0; i < 4; i++) blk_bits[i] = (i == 0);
    endtask

    task automatic bad_start(input int len);
        Start    = 1'b1;
        BlockLen = CW'(len);
        @(posedge Clock); #1;
        Start = 1'b0;
        check("start_err_pulse", Start_Err, 1);
        check("start_err_busy", Busy, 0);
        check("start_err_ready", bus.In_Ready, 0);
        @(posedge Clock); #1;
        check("start_err_once", Start_Err, 0);
        check("start_err_busy2", Busy, 0);
    endtask

    initial begin
        bus.In_Valid  = 1'b0;
        bus.In_Bit    = 1'b0;
        bus.Out_Ready = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_out_valid", bus.Out_Valid, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_in_ready", bus.In_Ready, 0);
        nReset = 1'b1;
        @(posedge Clock); #1;

        load_impulse();
        run_block(4, 0);
        check_impulse();

        run_block(4, 1);
        check_impulse();

        bad_start(0);
        bad_start(K_MAX + 1);

        for (int i = 0; i < 8; i++) blk_bits[i] = 1'($urandom);
        run_block(8, 3);

        blk_bits[0] = 1'b1;
        run_block(1, 0);

        // Abort a block after three bits with an asynchronous reset
        Start = 1'b1; BlockLen = CW'(8); bus.Out_Ready = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0; bus.In_Valid = 1'b1; bus.In_Bit = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        bus.In_Valid = 1'b0;
        nReset = 1'b0;
        #1;
        check("abort_valid", bus.Out_Valid, 0);
        check("abort_sys", bus.Out_Sys, 0);
        check("abort_par", bus.Out_Par, 0);
        check("abort_tail", bus.Out_Tail, 0);
        check("abort_busy", Busy, 0);
        check("abort_in_ready", bus.In_Ready, 0);
        @(posedge Clock); #1;
        check("abort_no_done", Done, 0);
        nReset = 1'b1;
        @(posedge Clock); #1;
        check("abort_no_done2", Done, 0);
        load_impulse();
        run_block(4, 0);
        check_impulse();

        for (int n = 0; n < 4; n++) begin
            int k = $urandom_range(1, 40);
            for (int i = 0; i < k; i++) blk_bits[i] = 1'($urandom);
            run_block(k, 2);
        end

        for (int i = 0; i < K_MAX; i++) blk_bits[i] = 1'($urandom);
        run_block(K_MAX, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
